// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings and width helper.
package led_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_FILL   = 2'd0,
        MODE_DOT    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    // Counter width for a range of n values; never below one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable divider: one-cycle tick every DIV enabled cycles, single clock domain.
module tick_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int unsigned DIV = 50000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CW   = clog2_min1(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Combinational so the caller can register its own response on the same edge.
    assign tick = enable && !clear && (count == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: fill bar, running dot, bounce and blink on a WIDTH-bit bank,
// advancing one step every DIV clock cycles.
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 50000000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] led_out,
    output logic             step_tick,
    output logic             wrap
);

    localparam int unsigned   PW       = clog2_min1(WIDTH + 1);
    localparam logic [PW-1:0] FILL_END = PW'(WIDTH);
    localparam logic [PW-1:0] DOT_END  = PW'(WIDTH - 1);

    mode_e            mode_in;
    mode_e            mode_q;
    logic             mode_chg_c;
    logic             tick;
    logic [PW-1:0]    pos, pos_step, pos_nxt;
    logic             up, up_step, up_nxt;
    logic [WIDTH-1:0] led_nxt;
    logic             step_nxt, wrap_nxt;

    assign mode_in    = mode_e'(mode);
    assign mode_chg_c = (mode_in != mode_q);

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (mode_chg_c),
        .tick    (tick)
    );

    // Map a step index to the LED image; dir mirrors the bank (blink is symmetric).
    function automatic logic [WIDTH-1:0] pattern_map(input mode_e m, input logic [PW-1:0] p,
                                                     input logic d);
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] r;
        v = '0;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case (m)
                MODE_FILL:              v[i] = (i < int'(p));
                MODE_DOT, MODE_BOUNCE:  v[i] = (i == int'(p));
                MODE_BLINK:             v[i] = (p != '0);
            endcase
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[int'(WIDTH) - 1 - i] = v[i];
        end
        return d ? r : v;
    endfunction

    // Next step index per mode; bounce flips direction on arrival at either end.
    always_comb begin
        pos_step = pos;
        up_step  = up;
        case (mode_q)
            MODE_FILL:   pos_step = (pos >= FILL_END) ? '0 : pos + PW'(1);
            MODE_DOT:    pos_step = (pos >= DOT_END)  ? '0 : pos + PW'(1);
            MODE_BOUNCE: begin
                pos_step = ((up && pos < DOT_END) || pos == '0) ? pos + PW'(1) : pos - PW'(1);
                if (pos_step == DOT_END) begin
                    up_step = 1'b0;
                end else if (pos_step == '0) begin
                    up_step = 1'b1;
                end
            end
            MODE_BLINK:  pos_step = (pos == '0) ? PW'(1) : '0;
        endcase
    end

    // Mode reload wins over a coincident tick.
    always_comb begin
        pos_nxt  = pos;
        up_nxt   = up;
        led_nxt  = led_out;
        step_nxt = 1'b0;
        wrap_nxt = 1'b0;
        if (mode_chg_c) begin
            pos_nxt = '0;
            up_nxt  = 1'b1;
            led_nxt = pattern_map(mode_in, '0, dir);
        end else if (tick) begin
            pos_nxt  = pos_step;
            up_nxt   = up_step;
            led_nxt  = pattern_map(mode_q, pos_step, dir);
            step_nxt = 1'b1;
            wrap_nxt = (pos_step == '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= MODE_FILL;
            pos       <= '0;
            up        <= 1'b1;
            led_out   <= '0;
            step_tick <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            mode_q    <= mode_in;
            pos       <= pos_nxt;
            up        <= up_nxt;
            led_out   <= led_nxt;
            step_tick <= step_nxt;
            wrap      <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: expected steps queued by stimulus, popped by monitors.
module tb_led_pattern_gen;
    import led_pattern_gen_pkg::*;

    typedef struct packed {
        logic [7:0] led;
        logic       wrap;
    } exp_t;

    localparam logic [7:0] FILL8  [9]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    localparam logic [7:0] DOTDN8 [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    localparam logic [7:0] BNC8   [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                           8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    localparam logic [3:0] FILL4  [10] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'h0};

    logic       clk;
    logic       rst_a, en_a, dir_a, step_a, wrap_a;
    logic [1:0] mode_a;
    logic [7:0] led_a;
    logic       rst_b, en_b, dir_b, step_b, wrap_b;
    logic [1:0] mode_b;
    logic [3:0] led_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   errors = 0;
    int   checks = 0;

    led_pattern_gen #(.WIDTH(8), .DIV(4)) u_dut_a (
        .clock(clk), .reset_n(rst_a), .enable(en_a), .mode(mode_a), .dir(dir_a),
        .led_out(led_a), .step_tick(step_a), .wrap(wrap_a)
    );

    led_pattern_gen #(.WIDTH(4), .DIV(1)) u_dut_b (
        .clock(clk), .reset_n(rst_b), .enable(en_b), .mode(mode_b), .dir(dir_b),
        .led_out(led_b), .step_tick(step_b), .wrap(wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] l, input logic w);
        exp_t t;
        t.led  = l;
        t.wrap = w;
        q_a.push_back(t);
    endtask

    task automatic push_b(input logic [3:0] l, input logic w);
        exp_t t;
        t.led  = {4'h0, l};
        t.wrap = w;
        q_b.push_back(t);
    endtask

    // Wait until the monitor has consumed every queued step, within a cycle budget.
    task automatic drain_a(input int budget);
        int n;
        n = 0;
        while (q_a.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q_a.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_a: %0d steps still pending after %0d cycles", q_a.size(), budget);
            q_a.delete();
        end
    endtask

    always @(negedge clk) begin
        if (step_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL step_a: unexpected step led=%h wrap=%b", led_a, wrap_a);
            end else begin
                ea = q_a.pop_front();
                if (led_a !== ea.led || wrap_a !== ea.wrap) begin
                    errors++;
                    $display("FAIL step_a: led=%h wrap=%b expected led=%h wrap=%b",
                             led_a, wrap_a, ea.led, ea.wrap);
                end
            end
        end else if (wrap_a) begin
            checks++;
            errors++;
            $display("FAIL wrap_a: wrap=1 without step_tick, expected 0");
        end
    end

    always @(negedge clk) begin
        if (step_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL step_b: unexpected step led=%h wrap=%b", led_b, wrap_b);
            end else begin
                eb = q_b.pop_front();
                if ({4'h0, led_b} !== eb.led || wrap_b !== eb.wrap) begin
                    errors++;
                    $display("FAIL step_b: led=%h wrap=%b expected led=%h wrap=%b",
                             led_b, wrap_b, eb.led, eb.wrap);
                end
            end
        end
    end

    initial begin
        rst_a = 1'b0; en_a = 1'b1; mode_a = MODE_FILL; dir_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b1; mode_b = MODE_FILL; dir_b = 1'b0;

        // Reset state
        #2;
        chk("reset_led", 32'(led_a), 32'h00);
        chk("reset_step", 32'(step_a), 32'h0);
        chk("reset_wrap", 32'(wrap_a), 32'h0);

        // Fill bar, then asynchronous reset mid-run
        repeat (2) @(negedge clk);
        #1 rst_a = 1'b1;
        push_a(8'h01, 1'b0);
        push_a(8'h03, 1'b0);
        drain_a(20);
        @(negedge clk);
        #3 rst_a = 1'b0;
        #1;
        chk("midrun_reset_led", 32'(led_a), 32'h00);
        chk("midrun_reset_step", 32'(step_a), 32'h0);
        @(negedge clk);
        #1 rst_a = 1'b1;
        for (int i = 0; i < 9; i++) push_a(FILL8[i], i == 8);
        drain_a(60);

        // Running dot from the MSB, then direction flip at pos 2
        mode_a = MODE_DOT;
        dir_a  = 1'b1;
        @(negedge clk);
        #1;
        chk("dot_reload_led", 32'(led_a), 32'h80);
        chk("dot_reload_step", 32'(step_a), 32'h0);
        for (int i = 0; i < 8; i++) push_a(DOTDN8[i], i == 7);
        drain_a(60);
        push_a(8'h40, 1'b0);
        push_a(8'h20, 1'b0);
        drain_a(20);
        dir_a = 1'b0;
        @(negedge clk);
        #1;
        chk("dir_flip_hold", 32'(led_a), 32'h20);
        push_a(8'h08, 1'b0);
        push_a(8'h10, 1'b0);
        push_a(8'h20, 1'b0);
        push_a(8'h40, 1'b0);
        push_a(8'h80, 1'b0);
        push_a(8'h01, 1'b1);
        drain_a(40);

        // Bounce: 14-step turn, ends shown once, wrap on return to 01
        mode_a = MODE_BOUNCE;
        @(negedge clk);
        #1;
        chk("bounce_reload_led", 32'(led_a), 32'h01);
        for (int i = 0; i < 14; i++) push_a(BNC8[i], i == 13);
        drain_a(80);

        // Mode change coinciding with a tick
        mode_a = MODE_DOT;
        @(negedge clk);
        #1;
        chk("dot2_reload_led", 32'(led_a), 32'h01);
        push_a(8'h02, 1'b0);
        drain_a(20);
        repeat (3) @(negedge clk);
        #1 mode_a = MODE_BLINK;
        @(negedge clk);
        #1;
        chk("blink_reload_led", 32'(led_a), 32'h00);
        chk("blink_reload_step", 32'(step_a), 32'h0);
        push_a(8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("blink_restart_gap", 32'(step_a), 32'h0);
        end
        @(negedge clk);
        #1;
        chk("blink_first_step", 32'(step_a), 32'h1);

        // Pause for 10 cycles mid-count, then resume from held count
        @(negedge clk);
        #1 en_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("pause_led", 32'(led_a), 32'hFF);
            chk("pause_step", 32'(step_a), 32'h0);
        end
        en_a = 1'b1;
        push_a(8'h00, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("resume_gap", 32'(step_a), 32'h0);
        end
        @(negedge clk);
        #1;
        chk("resume_step", 32'(step_a), 32'h1);
        chk("resume_popped", 32'(q_a.size()), 32'h0);
        en_a = 1'b0;

        // DIV=1, WIDTH=4: a step every cycle, wrap every fifth
        for (int i = 0; i < 10; i++) push_b(FILL4[i], (i % 5) == 4);
        rst_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("div1_step", 32'(step_b), 32'h1);
        end
        rst_b = 1'b0;
        chk("div1_popped", 32'(q_b.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
